// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the lamp-bus monitor.
//   - Lamp code constants (one-hot style codes driven by the controller).
//   - Per-channel checker state enum.
//   - Default minimum/maximum dwell limits.
//   - lamp_legal(): true when a code is one of the four defined lamps.
package traffic_pkg;

    localparam logic [3:0] RED   = 4'b0010;
    localparam logic [3:0] ALT   = 4'b0100;
    localparam logic [3:0] GREEN = 4'b1000;
    localparam logic [3:0] AMBER = 4'b0001;

    typedef enum logic {
        TRACK = 1'b0,
        SYNC  = 1'b1
    } chan_state_e;

    localparam int unsigned DEF_MIN_RED   = 32'd3;
    localparam int unsigned DEF_MIN_ALT   = 32'd20;
    localparam int unsigned DEF_MIN_GREEN = 32'd6;
    localparam int unsigned DEF_MIN_AMBER = 32'd12;
    localparam int unsigned DEF_MAX_DWELL = 32'd63;

    function automatic logic lamp_legal(input logic [3:0] code);
        case (code)
            RED, ALT, GREEN, AMBER: lamp_legal = 1'b1;
            default:                lamp_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/traffic_chan_mon.sv
// traffic_chan_mon: checker for one lamp channel.
// Tracks the previous code, how long it has been held (saturating at 127),
// whether the next RED exit must go to ALT, and a TRACK/SYNC state. After a
// code or sequence error the channel waits in SYNC for a RED and then accepts
// either exit from it before checking the phase order again.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   lamp_i          - lamp code sampled every cycle
//   clr_err_i       - clears the sticky flags (a same-cycle error wins)
//   err_*_o         - sticky illegal / sequence / dwell / stuck flags
//   cycles_o        - completed AMBER->RED cycles, wraps 255->0
//   is_green_o      - current sample is GREEN (unregistered, for conflict)
module traffic_chan_mon
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_RED   = DEF_MIN_RED,
    parameter int unsigned MIN_ALT   = DEF_MIN_ALT,
    parameter int unsigned MIN_GREEN = DEF_MIN_GREEN,
    parameter int unsigned MIN_AMBER = DEF_MIN_AMBER,
    parameter int unsigned MAX_DWELL = DEF_MAX_DWELL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] lamp_i,
    input  logic       clr_err_i,
    output logic       err_illegal_o,
    output logic       err_seq_o,
    output logic       err_dwell_o,
    output logic       err_stuck_o,
    output logic [7:0] cycles_o,
    output logic       is_green_o
);

    chan_state_e state_q, state_d;
    logic [3:0]  prev_q, prev_d;
    logic [6:0]  dwell_q, dwell_d;
    logic        next_alt_q, next_alt_d;
    logic        free_exit_q, free_exit_d;   // next exit from RED is unchecked
    logic [7:0]  cycles_q, cycles_d;
    logic        err_illegal_q, err_illegal_d;
    logic        err_seq_q, err_seq_d;
    logic        err_dwell_q, err_dwell_d;
    logic        err_stuck_q, err_stuck_d;

    logic        changed_s;
    logic        legal_s;
    logic        trans_ok_s;
    logic [6:0]  dwell_inc_s;
    logic        set_illegal_s, set_seq_s, set_dwell_s, set_stuck_s;

    function automatic logic [6:0] min_dwell(input logic [3:0] code);
        case (code)
            RED:     min_dwell = 7'(MIN_RED);
            ALT:     min_dwell = 7'(MIN_ALT);
            GREEN:   min_dwell = 7'(MIN_GREEN);
            AMBER:   min_dwell = 7'(MIN_AMBER);
            default: min_dwell = 7'd0;
        endcase
    endfunction

    assign changed_s   = (lamp_i != prev_q);
    assign legal_s     = lamp_legal(lamp_i);
    assign dwell_inc_s = (dwell_q == 7'd127) ? 7'd127 : (dwell_q + 7'd1);
    assign is_green_o  = (lamp_i == GREEN);

    // Phase-order check from the previous code to the current sample.
    always_comb begin
        case (prev_q)
            RED:     trans_ok_s = ((lamp_i == ALT)   && (next_alt_q  || free_exit_q)) ||
                                  ((lamp_i == GREEN) && (!next_alt_q || free_exit_q));
            ALT:     trans_ok_s = (lamp_i == RED);
            GREEN:   trans_ok_s = (lamp_i == AMBER);
            AMBER:   trans_ok_s = (lamp_i == RED);
            default: trans_ok_s = 1'b0;
        endcase
    end

    // Next-state logic: FSM, dwell counter, phase bookkeeping and error sets.
    always_comb begin
        state_d       = state_q;
        prev_d        = lamp_i;
        dwell_d       = dwell_q;
        next_alt_d    = next_alt_q;
        free_exit_d   = free_exit_q;
        cycles_d      = cycles_q;
        set_illegal_s = 1'b0;
        set_seq_s     = 1'b0;
        set_dwell_s   = 1'b0;
        set_stuck_s   = 1'b0;

        case (state_q)
            TRACK: begin
                if (changed_s) begin
                    dwell_d = 7'd1;
                    if (!legal_s) begin
                        set_illegal_s = 1'b1;
                        state_d       = SYNC;
                    end else if (!trans_ok_s) begin
                        set_seq_s = 1'b1;
                        state_d   = SYNC;
                    end else begin
                        // dwell_q still holds the count of the code being left
                        set_dwell_s = (dwell_q < min_dwell(prev_q));
                        free_exit_d = 1'b0;
                        if (prev_q == ALT) begin
                            next_alt_d = 1'b0;
                        end else if (prev_q == AMBER) begin
                            next_alt_d = 1'b1;
                            cycles_d   = cycles_q + 8'd1;
                        end else if (free_exit_q) begin
                            // first exit after resync decides the phase
                            next_alt_d = (lamp_i == ALT);
                        end else begin
                            next_alt_d = next_alt_q;
                        end
                    end
                end else begin
                    dwell_d = dwell_inc_s;
                    // fires once: the counter moves past MAX_DWELL right after
                    set_stuck_s = (dwell_q == 7'(MAX_DWELL));
                end
            end
            SYNC: begin
                dwell_d = changed_s ? 7'd1 : dwell_inc_s;
                if (!legal_s) begin
                    set_illegal_s = 1'b1;
                end else if (lamp_i == RED) begin
                    state_d     = TRACK;
                    dwell_d     = 7'd1;
                    free_exit_d = 1'b1;
                end else begin
                    state_d = SYNC;
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase

        err_illegal_d = (err_illegal_q & ~clr_err_i) | set_illegal_s;
        err_seq_d     = (err_seq_q     & ~clr_err_i) | set_seq_s;
        err_dwell_d   = (err_dwell_q   & ~clr_err_i) | set_dwell_s;
        err_stuck_d   = (err_stuck_q   & ~clr_err_i) | set_stuck_s;
    end

    // Channel state and sticky flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= TRACK;
            prev_q        <= RED;
            dwell_q       <= 7'd0;
            next_alt_q    <= 1'b1;
            free_exit_q   <= 1'b0;
            cycles_q      <= 8'd0;
            err_illegal_q <= 1'b0;
            err_seq_q     <= 1'b0;
            err_dwell_q   <= 1'b0;
            err_stuck_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            dwell_q       <= dwell_d;
            next_alt_q    <= next_alt_d;
            free_exit_q   <= free_exit_d;
            cycles_q      <= cycles_d;
            err_illegal_q <= err_illegal_d;
            err_seq_q     <= err_seq_d;
            err_dwell_q   <= err_dwell_d;
            err_stuck_q   <= err_stuck_d;
        end
    end

    assign err_illegal_o = err_illegal_q;
    assign err_seq_o     = err_seq_q;
    assign err_dwell_o   = err_dwell_q;
    assign err_stuck_o   = err_stuck_q;
    assign cycles_o      = cycles_q;

endmodule

// File: rtl/traffic_monitor.sv
// traffic_monitor: passive checker on the two-channel lamp bus.
// One traffic_chan_mon per channel; this level adds the cross-channel
// GREEN/GREEN conflict flag and the summary fault.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   lampA, lampB        - lamp codes of channel A and B
//   clr_err             - clears all sticky flags (a same-cycle error wins)
//   err_illegal/seq/dwell/stuck - sticky per-channel flags, [0]=A, [1]=B
//   err_conflict        - sticky, both channels GREEN in one sample
//   fault               - OR of all sticky flags
//   cycles_a, cycles_b  - completed-cycle counters
module traffic_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_RED   = DEF_MIN_RED,
    parameter int unsigned MIN_ALT   = DEF_MIN_ALT,
    parameter int unsigned MIN_GREEN = DEF_MIN_GREEN,
    parameter int unsigned MIN_AMBER = DEF_MIN_AMBER,
    parameter int unsigned MAX_DWELL = DEF_MAX_DWELL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] lampA,
    input  logic [3:0] lampB,
    input  logic       clr_err,
    output logic [1:0] err_illegal,
    output logic [1:0] err_seq,
    output logic [1:0] err_dwell,
    output logic [1:0] err_stuck,
    output logic       err_conflict,
    output logic       fault,
    output logic [7:0] cycles_a,
    output logic [7:0] cycles_b
);

    logic green_a_s, green_b_s;
    logic err_conflict_q, err_conflict_d;

    traffic_chan_mon #(
        .MIN_RED  (MIN_RED),
        .MIN_ALT  (MIN_ALT),
        .MIN_GREEN(MIN_GREEN),
        .MIN_AMBER(MIN_AMBER),
        .MAX_DWELL(MAX_DWELL)
    ) u_chan_a (
        .clk          (clk),
        .reset        (reset),
        .lamp_i       (lampA),
        .clr_err_i    (clr_err),
        .err_illegal_o(err_illegal[0]),
        .err_seq_o    (err_seq[0]),
        .err_dwell_o  (err_dwell[0]),
        .err_stuck_o  (err_stuck[0]),
        .cycles_o     (cycles_a),
        .is_green_o   (green_a_s)
    );

    traffic_chan_mon #(
        .MIN_RED  (MIN_RED),
        .MIN_ALT  (MIN_ALT),
        .MIN_GREEN(MIN_GREEN),
        .MIN_AMBER(MIN_AMBER),
        .MAX_DWELL(MAX_DWELL)
    ) u_chan_b (
        .clk          (clk),
        .reset        (reset),
        .lamp_i       (lampB),
        .clr_err_i    (clr_err),
        .err_illegal_o(err_illegal[1]),
        .err_seq_o    (err_seq[1]),
        .err_dwell_o  (err_dwell[1]),
        .err_stuck_o  (err_stuck[1]),
        .cycles_o     (cycles_b),
        .is_green_o   (green_b_s)
    );

    // Conflict flag next state; checked regardless of channel FSM state.
    always_comb begin
        err_conflict_d = (err_conflict_q & ~clr_err) | (green_a_s & green_b_s);
    end

    // Conflict flag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_conflict_q <= 1'b0;
        end else begin
            err_conflict_q <= err_conflict_d;
        end
    end

    assign err_conflict = err_conflict_q;
    assign fault        = (|err_illegal) | (|err_seq) | (|err_dwell) |
                          (|err_stuck) | err_conflict_q;

endmodule

// File: tb/tb_traffic_monitor.sv
module tb_traffic_monitor;
    import traffic_pkg::*;

    localparam logic [25:0] FULL  = 26'h3FF_FFFF;
    localparam logic [25:0] FLAGS = 26'h3FF_0000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] lampA = 4'b0010;
    logic [3:0] lampB = 4'b0010;
    logic       clr_err = 1'b0;
    logic [1:0] err_illegal, err_seq, err_dwell, err_stuck;
    logic       err_conflict, fault;
    logic [7:0] cycles_a, cycles_b;

    always #5 clk = ~clk;

    traffic_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .lampA       (lampA),
        .lampB       (lampB),
        .clr_err     (clr_err),
        .err_illegal (err_illegal),
        .err_seq     (err_seq),
        .err_dwell   (err_dwell),
        .err_stuck   (err_stuck),
        .err_conflict(err_conflict),
        .fault       (fault),
        .cycles_a    (cycles_a),
        .cycles_b    (cycles_b)
    );

    logic [25:0] exp_q[$];
    logic [25:0] msk_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic logic [25:0] expv(input logic [1:0] il, input logic [1:0] sq,
                                         input logic [1:0] dw, input logic [1:0] st,
                                         input logic cf, input logic [7:0] ca,
                                         input logic [7:0] cb);
        logic f;
        f = (|il) | (|sq) | (|dw) | (|st) | cf;
        return {il, sq, dw, st, cf, f, ca, cb};
    endfunction

    function automatic logic [25:0] obs();
        return {err_illegal, err_seq, err_dwell, err_stuck, err_conflict, fault, cycles_a, cycles_b};
    endfunction

    // legal schedule: RED x3, ALT x24, RED x4, GREEN x8, AMBER x16 (55 samples)
    function automatic logic [3:0] sched(input int idx);
        int p;
        p = idx % 55;
        if (p < 3) return RED;
        else if (p < 27) return ALT;
        else if (p < 31) return RED;
        else if (p < 39) return GREEN;
        else return AMBER;
    endfunction

    task automatic push(input string n, input logic [25:0] e, input logic [25:0] m);
        exp_q.push_back(e);
        msk_q.push_back(m);
        name_q.push_back(n);
    endtask

    task automatic tick(input logic [3:0] a, input logic [3:0] b, input logic clr);
        @(negedge clk);
        reset = 1'b0; lampA = a; lampB = b; clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        reset = 1'b1; lampA = a; lampB = b; clr_err = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [25:0] e, m; string nm;
        push("reset_state", expv(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'd0, 8'd0), FULL);
        do_reset(4'b1111, 4'b1111);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front(); m = msk_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if ((obs() & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL %s: observed %h expected %h", nm, obs() & m, e & m);
            end
        end
    endtask

    task automatic test_legal();
        logic [25:0] e, m; string nm; logic [3:0] b;
        do_reset(RED, RED);
        for (int t = 0; t < 194; t++) begin
            b = (t < 28) ? RED : sched(t - 28);
            if (t == 55)  push("legal_cyc1",  expv(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'd1, 8'd0), FULL);
            if (t == 165) push("legal_cyc3a", expv(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'd3, 8'd2), FULL);
            if (t == 193) push("legal_end",   expv(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'd3, 8'd3), FULL);
            tick(sched(t), b, 1'b0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front(); m = msk_q.pop_front(); nm = name_q.pop_front();
                n_cmp++;
                if ((obs() & m) !== (e & m)) begin
                    n_fail++;
                    $display("FAIL %s: observed %h expected %h", nm, obs() & m, e & m);
                end
            end
        end
    endtask

    task automatic test_seq();
        logic [25:0] e, m; string nm; logic [3:0] a;
        do_reset(RED, RED);
        for (int t = 0; t <= 80; t++) begin
            if (t == 0) a = RED;
            else if (t < 9)  a = GREEN;
            else if (t < 25) a = AMBER;
            else if (t < 28) a = RED;
            else if (t < 52) a = ALT;
            else if (t < 56) a = RED;
            else if (t < 64) a = GREEN;
            else if (t < 80) a = AMBER;
            else a = RED;
            if (t == 1)  push("seq_red_green", expv(2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 8'd0, 8'd0), FULL);
            if (t == 80) push("seq_resync",    expv(2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 8'd0, 8'd0), FLAGS);
            tick(a, sched(t), 1'b0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front(); m = msk_q.pop_front(); nm = name_q.pop_front();
                n_cmp++;
                if ((obs() & m) !== (e & m)) begin
                    n_fail++;
                    $display("FAIL %s: observed %h expected %h", nm, obs() & m, e & m);
                end
            end
        end
    endtask

    task automatic test_dwell();
        logic [25:0] e, m; string nm; logic [3:0] b;
        do_reset(RED, RED);
        for (int t = 0; t <= 90; t++) begin
            if (t < 12) b = RED;
            else if (t < 36) b = ALT;
            else if (t < 40) b = RED;
            else if (t < 44) b = GREEN;
            else if (t < 60) b = AMBER;
            else if (t < 64) b = RED;
            else if (t < 88) b = ALT;
            else b = RED;
            if (t == 44) push("dwell_short_green", expv(2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 8'd0, 8'd0), FULL);
            if (t == 90) push("dwell_track_on",    expv(2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 8'd1, 8'd1), FULL);
            tick(sched(t), b, 1'b0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front(); m = msk_q.pop_front(); nm = name_q.pop_front();
                n_cmp++;
                if ((obs() & m) !== (e & m)) begin
                    n_fail++;
                    $display("FAIL %s: observed %h expected %h", nm, obs() & m, e & m);
                end
            end
        end
    endtask

    task automatic test_illegal_clear();
        logic [25:0] e, m; string nm;
        logic [3:0] as [4];
        logic       cl [4];
        as = '{RED, 4'b0110, RED, RED};
        cl = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset(RED, RED);
        for (int t = 0; t < 4; t++) begin
            if (t == 1) push("illegal_a",  expv(2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'd0, 8'd0), FULL);
            if (t == 3) push("clr_err_ok", expv(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'd0, 8'd0), FULL);
            tick(as[t], RED, cl[t]);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front(); m = msk_q.pop_front(); nm = name_q.pop_front();
                n_cmp++;
                if ((obs() & m) !== (e & m)) begin
                    n_fail++;
                    $display("FAIL %s: observed %h expected %h", nm, obs() & m, e & m);
                end
            end
        end
    endtask

    task automatic test_conflict();
        logic [25:0] e, m; string nm;
        do_reset(RED, RED);
        tick(RED, RED, 1'b0);
        // RED->GREEN with next_alt=1 also trips both seq flags; all win over clr
        push("conflict_vs_clr", expv(2'b00, 2'b11, 2'b00, 2'b00, 1'b1, 8'd0, 8'd0), FULL);
        tick(GREEN, GREEN, 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front(); m = msk_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if ((obs() & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL %s: observed %h expected %h", nm, obs() & m, e & m);
            end
        end
    endtask

    task automatic test_stuck();
        logic [25:0] e, m; string nm;
        do_reset(RED, RED);
        for (int t = 0; t < 64; t++) begin
            if (t == 62) push("stuck_63_ok", expv(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'd0, 8'd1), FULL);
            if (t == 63) push("stuck_64",    expv(2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 8'd0, 8'd1), FULL);
            tick(RED, sched(t), 1'b0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front(); m = msk_q.pop_front(); nm = name_q.pop_front();
                n_cmp++;
                if ((obs() & m) !== (e & m)) begin
                    n_fail++;
                    $display("FAIL %s: observed %h expected %h", nm, obs() & m, e & m);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [25:0] e, m; string nm; logic [3:0] a, b;
        do_reset(RED, RED);
        for (int t = 0; t < 8; t++) begin
            a = (t < 3) ? RED : ALT;
            b = (t == 3) ? 4'b1111 : RED;
            if (t == 7) push("pending_err", expv(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 8'd0, 8'd0), FULL);
            tick(a, b, 1'b0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front(); m = msk_q.pop_front(); nm = name_q.pop_front();
                n_cmp++;
                if ((obs() & m) !== (e & m)) begin
                    n_fail++;
                    $display("FAIL %s: observed %h expected %h", nm, obs() & m, e & m);
                end
            end
        end
        // lamps during the reset cycle are a GREEN/GREEN conflict and must be ignored
        push("mid_reset", expv(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'd0, 8'd0), FULL);
        do_reset(GREEN, GREEN);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front(); m = msk_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if ((obs() & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL %s: observed %h expected %h", nm, obs() & m, e & m);
            end
        end
        for (int t = 0; t < 6; t++) begin
            if (t == 5) push("post_reset_alt", expv(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'd0, 8'd0), FULL);
            tick((t < 3) ? RED : ALT, RED, 1'b0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front(); m = msk_q.pop_front(); nm = name_q.pop_front();
                n_cmp++;
                if ((obs() & m) !== (e & m)) begin
                    n_fail++;
                    $display("FAIL %s: observed %h expected %h", nm, obs() & m, e & m);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_legal();
        test_seq();
        test_dwell();
        test_illegal_clear();
        test_conflict();
        test_stuck();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_monitor.md
# traffic_monitor

Passive checker on the two-channel lamp bus driven by the traffic controller. Samples `lampA`/`lampB` every cycle and verifies four things: legal lamp codes, legal phase order, minimum and maximum dwell times, and no simultaneous green. Violations are reported as sticky error flags and a summary `fault`. The block sits beside the controller in the top level and feeds the fault/status register.

## Interface
- `MIN_RED`, default 3: minimum consecutive samples of RED before it may change.
- `MIN_ALT`, default 20: minimum samples of ALT.
- `MIN_GREEN`, default 6: minimum samples of GREEN.
- `MIN_AMBER`, default 12: minimum samples of AMBER.
- `MAX_DWELL`, default 63: any code held more than this many samples is a stuck fault.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `lampA` in 4: channel A lamp code.
- `lampB` in 4: channel B lamp code.
- `clr_err` in 1: clears all sticky flags.
- `err_illegal` out 2: sticky, [0]=A, [1]=B; code not in {RED, ALT, GREEN, AMBER}.
- `err_seq` out 2: sticky; illegal phase transition.
- `err_dwell` out 2: sticky; code left before its MIN.
- `err_stuck` out 2: sticky; dwell exceeded MAX_DWELL.
- `err_conflict` out 1: sticky; both channels GREEN in the same sample.
- `fault` out 1: OR of all sticky flags.
- `cycles_a`, `cycles_b` out 8 each: completed-cycle counters, wrap 255→0.

## Operation
- Lamp codes: RED=4'b0010, ALT=4'b0100, GREEN=4'b1000, AMBER=4'b0001. Every other value is illegal.
- Legal transitions:
  - RED→ALT, only when `next_alt`=1.
  - ALT→RED, which clears `next_alt`.
  - RED→GREEN, only when `next_alt`=0.
  - GREEN→AMBER.
  - AMBER→RED, which sets `next_alt` and increments that channel's cycle counter.
- Per-channel state:
  - `prev` (4 bits).
  - `dwell` (7 bits, saturating at 127). It is 1 on the first sample of a new code and increments while the code is unchanged.
  - `next_alt` flag.
  - FSM {TRACK, SYNC}.
- TRACK, sample differs from `prev`:
  - Illegal code: set err_illegal and go to SYNC.
  - Illegal transition: set err_seq and go to SYNC.
  - Otherwise, if the `dwell` of the old code is below its MIN, set err_dwell and stay in TRACK.
- TRACK, sample equal to `prev`: if `dwell`==MAX_DWELL and the sample is unchanged again, set err_stuck once per dwell interval.
- SYNC:
  - No seq or dwell checks. Illegal codes still flag err_illegal.
  - The first legal RED sample returns the channel to TRACK with `dwell`=1.
  - The first exit from that RED may be to ALT or GREEN; `next_alt` is then set consistently with the exit taken.
- Conflict: lampA==GREEN and lampB==GREEN in the same sample sets err_conflict, in any FSM state.
- Sticky flags: `clr_err` clears all of them. If `clr_err` and a new error occur in the same cycle, the error wins (the flag stays 1).
- `clr_err` does not affect the FSMs, dwell counters or cycle counters.

## Timing
- All outputs are registered. An input sampled at edge N shows its flag effect after edge N, i.e. visible during cycle N+1.
- Reset values:
  - All flags, `fault` and cycle counters are 0.
  - Both channels: TRACK, `prev`=RED, `dwell`=0, `next_alt`=1. This matches the controller, whose reset also drives RED.
- The first sample after reset is RED, which gives `dwell`=1 with no transition check.
- Reset mid-operation: everything returns to the reset values on that edge, and lamp inputs in the reset cycle are ignored.
- `fault` is computed from the registered flags and lags them by zero cycles (combinational OR of registers).
- The dwell comparison uses the count of the old code, taken before the counter reloads.

## Structure
- Package `traffic_pkg`:
  - Lamp code constants RED/ALT/GREEN/AMBER.
  - Channel-state enum {TRACK, SYNC}.
  - Default MIN/MAX dwell constants.
  - A function `lamp_legal(code)`.
- Sub-module `traffic_chan_mon`, instantiated twice:
  - Contains the per-channel FSM, dwell counter, `next_alt`, the cycle counter and the sticky illegal/seq/dwell/stuck flags.
  - Also outputs `is_green` to the top for the conflict check.
- The top holds the conflict flag, `fault` and the shared `clr_err` fan-out.

## Test plan
- Drive both channels with a legal schedule (A: RED×3, ALT×24, RED×4, GREEN×8, AMBER×16, repeat; B offset by 28 cycles) for 3 cycles → all flags 0, `cycles_a`=`cycles_b`=3.
- Channel A RED→GREEN directly after reset (`next_alt`=1) → `err_seq[0]`=1 the cycle after. Then after A returns RED, A resyncs and no further flags are raised on a legal schedule.
- Channel B GREEN held only 4 samples before AMBER (MIN_GREEN=6) → `err_dwell[1]`=1, B stays in TRACK, and later legal phases raise no new flags.
- lampA=4'b0110 for one sample → `err_illegal[0]`=1, `fault`=1. Pulsing `clr_err` clears both, provided no error occurs in the same cycle.
- lampA and lampB both GREEN for 1 sample while `clr_err`=1 → `err_conflict`=1 (error wins). Channel A held RED for 64 samples → `err_stuck[0]`=1.
- Assert reset mid-ALT with errors pending → flags and counters are 0 after the edge, and a subsequent RED→ALT raises no error.
